// File: rtl/cpu_core_gen2.sv
// cpu_core_gen2: two-cycle FETCH/EXEC accumulator core.
// Program ROM and data RAM are external; both are read combinationally.
module cpu_core_gen2 #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] rom_addr,
  input  logic [W-1:0]  rom_data,
  output logic [AW-1:0] ram_addr,
  input  logic [W-1:0]  ram_rdata,
  output logic [W-1:0]  ram_wdata,
  output logic          ram_we,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] pc_q, pc_d;
  logic [5:0]    ir_q, ir_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  q_q, q_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  out_q, out_d;
  logic          ov_q, ov_d;
  logic          hlt_q, hlt_d;

  logic [2:0]    op;
  logic [1:0]    rsel;
  logic [2:0]    cond;
  logic [W-1:0]  rval;
  logic          taken;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] imm_pc;
  logic          wr_en;
  logic [W-1:0]  wr_data;

  logic is_ldi, is_ld, is_st, is_add;
  logic is_sub, is_jmp, is_out, is_hlt;

  // ir keeps only the opcode and the low operand bits
  assign op     = ir_q[5:3];
  assign cond   = ir_q[2:0];
  assign rsel   = ir_q[1:0];
  assign pc_inc = pc_q + AW'(1);

  assign is_ldi = (op == 3'd0);
  assign is_ld  = (op == 3'd1);
  assign is_st  = (op == 3'd2);
  assign is_add = (op == 3'd3);
  assign is_sub = (op == 3'd4);
  assign is_jmp = (op == 3'd5);
  assign is_out = (op == 3'd6);
  assign is_hlt = (op == 3'd7);

  // X and jump immediates are zero-extended when AW exceeds W
  generate
    if (AW > W) begin : g_ext
      assign ram_addr = {{(AW - W){1'b0}}, x_q};
      assign imm_pc   = {{(AW - W){1'b0}}, rom_data};
    end else begin : g_trunc
      assign ram_addr = x_q[AW-1:0];
      assign imm_pc   = rom_data[AW-1:0];
    end
  endgenerate

  assign rom_addr  = pc_q;
  assign ram_wdata = rval;
  assign ram_we    = (state_q == S_EXEC) & is_st & ~reset;
  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign halted    = hlt_q;

  // operand register select
  always_comb begin
    rval = a_q;
    case (rsel)
      2'd0: rval = a_q;
      2'd1: rval = b_q;
      2'd2: rval = x_q;
      2'd3: rval = q_q;
    endcase
  end

  // jump condition, A and carry as they stand entering EXEC
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0:    taken = 1'b1;
      3'd1:    taken = (a_q == '0);
      3'd2:    taken = carry_q;
      3'd3:    taken = (a_q != '0);
      default: taken = 1'b0;
    endcase
  end

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    q_d     = q_q;
    carry_d = carry_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    hlt_d   = hlt_q;
    wr_en   = 1'b0;
    wr_data = rom_data;
    case (state_q)
      S_FETCH: begin
        ir_d    = {rom_data[7:5], rom_data[2:0]};
        pc_d    = pc_inc;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (1'b1)
          is_ldi: begin
            wr_en   = 1'b1;
            wr_data = rom_data;
            pc_d    = pc_inc;
          end
          is_ld: begin
            wr_en   = 1'b1;
            wr_data = ram_rdata;
          end
          is_st: begin
          end
          is_add: begin
            {carry_d, a_d} = {1'b0, a_q} + {1'b0, rval};
          end
          is_sub: begin
            a_d     = a_q - rval;
            carry_d = (a_q >= rval);
          end
          is_jmp: begin
            pc_d = taken ? imm_pc : pc_inc;
          end
          is_out: begin
            out_d = rval;
            ov_d  = 1'b1;
          end
          is_hlt: begin
            hlt_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
        if (wr_en) begin
          case (rsel)
            2'd0: a_d = wr_data;
            2'd1: b_d = wr_data;
            2'd2: x_d = wr_data;
            2'd3: q_d = wr_data;
          endcase
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // state registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      q_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      hlt_q   <= hlt_d;
    end
  end

endmodule

// File: tb/tb_cpu_core_gen2.sv
// tb_cpu_core_gen2: instruction-level model run in lockstep
// with a W=8/AW=8 and a W=16/AW=10 core.
module tb_cpu_core_gen2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [7:0]  ra8, rd8, aa8, rr8, wd8, od8;
  logic        we8, ov8, h8;
  logic [9:0]  ra16, aa16;
  logic [15:0] rd16, rr16, wd16, od16;
  logic        we16, ov16, h16;

  logic [15:0] rom [1024];
  logic [7:0]  ram8 [256];
  logic [15:0] ram16 [1024];

  int vectors = 0;
  int errs = 0;

  int mode, dmask, amask;
  int o_ra, o_raddr, o_wd, o_we, o_out, o_ov, o_hlt;

  int m_pc, m_carry, m_out, m_ov, m_halt;
  int m_reg [4];
  int m_ram [1024];

  always #5 clk = ~clk;

  assign rd8  = rom[ra8][7:0];
  assign rd16 = rom[ra16];
  assign rr8  = ram8[aa8];
  assign rr16 = ram16[aa16];

  always @(posedge clk) begin
    if (we8) ram8[aa8] <= wd8;
    if (we16) ram16[aa16] <= wd16;
  end

  cpu_core_gen2 #(.W(8), .AW(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .rom_addr(ra8), .rom_data(rd8),
    .ram_addr(aa8), .ram_rdata(rr8),
    .ram_wdata(wd8), .ram_we(we8),
    .out_data(od8), .out_valid(ov8),
    .halted(h8)
  );

  cpu_core_gen2 #(.W(16), .AW(10)) u_dut16 (
    .clk(clk), .reset(reset),
    .rom_addr(ra16), .rom_data(rd16),
    .ram_addr(aa16), .ram_rdata(rr16),
    .ram_wdata(wd16), .ram_we(we16),
    .out_data(od16), .out_valid(ov16),
    .halted(h16)
  );

  always_comb begin
    if (mode == 0) begin
      o_ra    = 32'(ra8);
      o_raddr = 32'(aa8);
      o_wd    = 32'(wd8);
      o_we    = 32'(we8);
      o_out   = 32'(od8);
      o_ov    = 32'(ov8);
      o_hlt   = 32'(h8);
    end else begin
      o_ra    = 32'(ra16);
      o_raddr = 32'(aa16);
      o_wd    = 32'(wd16);
      o_we    = 32'(we16);
      o_out   = 32'(od16);
      o_ov    = 32'(ov16);
      o_hlt   = 32'(h16);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int romw(input int a);
    if (mode == 0) return 32'(rom[a][7:0]);
    return 32'(rom[a]);
  endfunction

  task automatic set_mode(input int md);
    mode  = md;
    dmask = (md != 0) ? 'hFFFF : 'hFF;
    amask = (md != 0) ? 'h3FF : 'hFF;
  endtask

  task automatic m_reset();
    m_pc = 0;
    m_carry = 0;
    m_out = 0;
    m_ov = 0;
    m_halt = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 16'h00E0;
  endtask

  task automatic put(input int a, input int v);
    rom[a] = v[15:0];
  endtask

  task automatic fill_ram();
    int v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom & dmask;
      m_ram[i] = v;
      if (i < 256) ram8[i] = v[7:0];
      ram16[i] = v[15:0];
    end
  endtask

  task automatic reset_on();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pc", o_ra, 0);
    chk("rst_we", o_we, 0);
    chk("rst_ov", o_ov, 0);
    chk("rst_out", o_out, 0);
    chk("rst_hlt", o_hlt, 0);
  endtask

  task automatic reset_off();
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    #1;
  endtask

  // executes one instruction in the model and checks the EXEC cycle
  task automatic step();
    int ir, op, r, cond, pc1, xa, s, imm, tk;
    ir   = romw(m_pc) & 'hFF;
    op   = ir >> 5;
    r    = ir & 3;
    cond = ir & 7;
    pc1  = (m_pc + 1) & amask;
    xa   = m_reg[2] & amask;
    chk("e_pc", o_ra, pc1);
    chk("e_raddr", o_raddr, xa);
    chk("e_we", o_we, (op == 2) ? 1 : 0);
    if (op == 2) chk("e_wdata", o_wd, m_reg[r]);
    chk("e_ov", o_ov, 0);
    chk("e_hlt", o_hlt, 0);
    m_ov = 0;
    m_pc = pc1;
    case (op)
      0: begin
        m_reg[r] = romw(pc1);
        m_pc = (pc1 + 1) & amask;
      end
      1: m_reg[r] = m_ram[xa];
      2: m_ram[xa] = m_reg[r];
      3: begin
        s = m_reg[0] + m_reg[r];
        m_carry = (s > dmask) ? 1 : 0;
        m_reg[0] = s & dmask;
      end
      4: begin
        m_carry = (m_reg[0] >= m_reg[r]) ? 1 : 0;
        m_reg[0] = (m_reg[0] - m_reg[r]) & dmask;
      end
      5: begin
        imm = romw(pc1) & amask;
        case (cond)
          0: tk = 1;
          1: tk = (m_reg[0] == 0) ? 1 : 0;
          2: tk = m_carry;
          3: tk = (m_reg[0] != 0) ? 1 : 0;
          default: tk = 0;
        endcase
        m_pc = (tk != 0) ? imm : ((pc1 + 1) & amask);
      end
      6: begin
        m_out = m_reg[r];
        m_ov = 1;
      end
      default: m_halt = 1;
    endcase
  endtask

  task automatic run_prog(input int max_instr);
    for (int i = 0; i < max_instr && m_halt == 0; i++) begin
      chk("f_pc", o_ra, m_pc);
      chk("f_we", o_we, 0);
      chk("f_ov", o_ov, m_ov);
      chk("f_out", o_out, m_out);
      chk("f_hlt", o_hlt, 0);
      @(negedge clk);
      step();
      @(negedge clk);
    end
    if (m_halt != 0) begin
      for (int i = 0; i < 3; i++) begin
        chk("h_hlt", o_hlt, 1);
        chk("h_pc", o_ra, m_pc);
        chk("h_we", o_we, 0);
        chk("h_ov", o_ov, 0);
        chk("h_out", o_out, m_out);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    set_mode(0);
    clear_rom();

    reset_on();
    clear_rom();
    put(0, 'h00); put(1, 'h5A); put(2, 'hC0); put(3, 'hE0);
    fill_ram();
    reset_off();
    run_prog(10);
    chk("t_ldout", o_out, 'h5A);

    reset_on();
    clear_rom();
    put(0, 'h00); put(1, 'hFF); put(2, 'h01); put(3, 'h01);
    put(4, 'h61); put(5, 'hA2); put(6, 'h08); put(7, 'hE0);
    put(8, 'hC0); put(9, 'hE0);
    reset_off();
    run_prog(10);
    chk("t_carry_pc", o_ra, 10);
    chk("t_carry_out", o_out, 0);

    reset_on();
    clear_rom();
    put(0, 'h00); put(1, 'h03); put(2, 'h01); put(3, 'h01);
    put(4, 'hC0); put(5, 'h81); put(6, 'hA3); put(7, 'h04);
    put(8, 'hE0);
    reset_off();
    run_prog(20);
    chk("t_loop_hlt", o_hlt, 1);
    chk("t_loop_out", o_out, 1);

    reset_on();
    clear_rom();
    put(0, 'h02); put(1, 'h10); put(2, 'h00); put(3, 'hC3);
    put(4, 'h40); put(5, 'h00); put(6, 'h00); put(7, 'h21);
    put(8, 'hC1); put(9, 'hE0);
    fill_ram();
    ram8[16] = 8'hEE;
    m_ram[16] = 'hEE;
    reset_off();
    run_prog(2);
    @(negedge clk);
    chk("t_st_we", o_we, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t_rst_we", o_we, 0);
    chk("t_rst_pc", o_ra, 0);
    chk("t_rst_ov", o_ov, 0);
    chk("t_rst_out", o_out, 0);
    @(posedge clk);
    #1;
    chk("t_rst_nowr", 32'(ram8[16]), 'hEE);
    reset_off();
    run_prog(20);
    chk("t_st_mem", 32'(ram8[16]), 'hC3);
    chk("t_ld_out", o_out, 'hC3);

    reset_on();
    set_mode(1);
    clear_rom();
    put(0, 'h00); put(1, 'h8000); put(2, 'h60); put(3, 'hC0);
    put(4, 'hA0); put(5, 'h3FF); put('h3FF, 'hA1);
    fill_ram();
    reset_off();
    run_prog(5);
    chk("t16_pc", o_ra, 0);
    chk("t16_out", o_out, 0);
    run_prog(4);

    for (int p = 0; p < 24; p++) begin
      reset_on();
      set_mode(p & 1);
      for (int i = 0; i < 1024; i++) put(i, $urandom & dmask);
      fill_ram();
      reset_off();
      run_prog(80);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
